// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction fetch unit.
//   - INSTR_W            : instruction word width
//   - NOP_INSTR_DEFAULT  : word returned for addresses outside the ROM
//   - fetch_entry_t      : one buffered fetch result {pc, instr}
//   - fifo_state_e       : occupancy of the 2-entry skid FIFO
//   - fifo_occupancy()   : number of entries held in a given FIFO state
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    function automatic logic [1:0] fifo_occupancy(input fifo_state_e state);
        logic [1:0] entries;
        case (state)
            FIFO_ONE:  entries = 2'd1;
            FIFO_FULL: entries = 2'd2;
            default:   entries = 2'd0;
        endcase
        return entries;
    endfunction

endpackage : fetch_pkg

// File: rtl/instr_rom.sv
// -----------------------------------------------------------------------------
// instr_rom
//   Instruction ROM with a one-cycle synchronous read. The read register only
//   updates when en is high, so the word stays put while no request is made.
//   Every word powers up holding NOP_INSTR.
//
// Ports
//   clk    in   1        clock, read register updates on rising edge
//   en     in   1        read enable (accepted fetch request)
//   addr   in   ADDR_W   word index
//   rdata  out  INSTR_W  word at addr, valid the cycle after en
// -----------------------------------------------------------------------------
module instr_rom
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter string              INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [INSTR_W-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef logic [DEPTH-1:0][INSTR_W-1:0] rom_image_t;

    // Builds the power-up image: NOP in every word.
    function automatic rom_image_t load_image();
        rom_image_t image;
        for (int i = 0; i < int'(DEPTH); i++) begin
            image[i] = NOP_INSTR;
        end
        return image;
    endfunction

    rom_image_t rom_mem = load_image();

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= rom_mem[addr];
        end
    end

endmodule : instr_rom

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Responder to the program counter's address interface. Each accepted word
//   address reads the instruction ROM; one cycle later the ROM word and the
//   registered address form a response that is pushed into a 2-entry skid
//   FIFO. The FIFO head is presented to the IF/ID stage. pc_hold freezes the
//   PC whenever buffered plus in-flight fetches could reach two, and flush
//   throws away everything fetched so far while still accepting the branch
//   target presented in the same cycle.
//
// Ports
//   clk          in   1   clock, all state on rising edge
//   reset        in   1   asynchronous, active-low
//   pc_addr      in   32  word address from the PC
//   pc_valid     in   1   pc_addr is a live request
//   pc_hold      out  1   request not accepted this cycle, PC must not advance
//   flush        in   1   taken branch: drop in-flight and buffered fetches
//   id_stall     in   1   IF/ID cannot take an instruction this cycle
//   instr        out  32  head instruction (0 when nothing buffered)
//   instr_pc     out  32  address of instr (0 when nothing buffered)
//   instr_valid  out  1   instr/instr_pc are valid
//   fetch_count  out  32  instructions delivered to IF/ID, wraps at 2**32
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter string              INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pc_addr,
    input  logic                pc_valid,
    output logic                pc_hold,
    input  logic                flush,
    input  logic                id_stall,
    output logic [INSTR_W-1:0]  instr,
    output logic [31:0]         instr_pc,
    output logic                instr_valid,
    output logic [31:0]         fetch_count
);

    // ------------------------------------------------------------------
    // Request / in-flight stage
    // ------------------------------------------------------------------
    logic               req;
    logic [INSTR_W-1:0] rom_rdata;
    logic               inflight_q;
    logic [31:0]        resp_pc_q;
    logic               resp_oor_q;
    fetch_entry_t       resp_entry;

    assign req = pc_valid & ~pc_hold;

    instr_rom #(
        .ADDR_W    (ADDR_W),
        .NOP_INSTR (NOP_INSTR),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk   (clk),
        .en    (req),
        .addr  (pc_addr[ADDR_W-1:0]),
        .rdata (rom_rdata)
    );

    // The in-flight flag follows req even during a flush: the flush only
    // kills the response already in flight (push is gated below), while the
    // branch target accepted in the same cycle must still come back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            resp_pc_q  <= '0;
            resp_oor_q <= 1'b0;
        end else begin
            inflight_q <= req;
            if (req) begin
                resp_pc_q  <= pc_addr;
                resp_oor_q <= |pc_addr[31:ADDR_W];
            end
        end
    end

    // Out-of-range addresses still index the ROM with their low bits, so the
    // word is replaced here; the full address is kept for the branch adder.
    assign resp_entry = '{pc: resp_pc_q, instr: (resp_oor_q ? NOP_INSTR : rom_rdata)};

    // ------------------------------------------------------------------
    // 2-entry skid FIFO, entry 0 is always the head
    // ------------------------------------------------------------------
    fifo_state_e  fifo_state_q;
    fifo_state_e  fifo_state_d;
    fetch_entry_t fifo_q [FIFO_DEPTH];
    fetch_entry_t fifo_d [FIFO_DEPTH];
    logic [31:0]  fetch_count_q;
    logic [31:0]  fetch_count_d;
    logic         push;
    logic         pop;
    logic [2:0]   pending;

    assign instr_valid = (fifo_state_q != FIFO_EMPTY);
    assign push        = inflight_q & ~flush;
    assign pop         = instr_valid & ~id_stall & ~flush;

    // Counts what is buffered plus what will land next cycle. A same-cycle
    // pop is deliberately ignored so the FIFO can never overflow.
    assign pending = {1'b0, fifo_occupancy(fifo_state_q)} + {2'b00, inflight_q};
    assign pc_hold = ~flush & (pending >= 3'd2);

    always_comb begin
        fifo_state_d  = fifo_state_q;
        fifo_d        = fifo_q;
        fetch_count_d = fetch_count_q + {31'd0, pop};

        if (flush) begin
            fifo_state_d = FIFO_EMPTY;
        end else begin
            case (fifo_state_q)
                FIFO_EMPTY: begin
                    if (push) begin
                        fifo_d[0]    = resp_entry;
                        fifo_state_d = FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            fifo_d[1]    = resp_entry;
                            fifo_state_d = FIFO_FULL;
                        end
                        2'b01: begin
                            fifo_state_d = FIFO_EMPTY;
                        end
                        2'b11: begin
                            // Head leaves and the new word takes its place.
                            fifo_d[0]    = resp_entry;
                        end
                        default: begin
                        end
                    endcase
                end
                FIFO_FULL: begin
                    // pc_hold keeps push low here.
                    if (pop) begin
                        fifo_d[0]    = fifo_q[1];
                        fifo_state_d = FIFO_ONE;
                    end
                end
                default: begin
                    fifo_state_d = FIFO_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_state_q  <= FIFO_EMPTY;
            fetch_count_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            fifo_state_q  <= fifo_state_d;
            fetch_count_q <= fetch_count_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // Stale entries may remain in the array after a pop or flush; the
    // outputs are forced to zero whenever nothing is buffered.
    assign instr       = instr_valid ? fifo_q[0].instr : '0;
    assign instr_pc    = instr_valid ? fifo_q[0].pc    : '0;
    assign fetch_count = fetch_count_q;

    // A push into a full FIFO would mean the pc_hold rule was broken.
    no_push_when_full : assert property (
        @(posedge clk) disable iff (!reset) !(push && (fifo_state_q == FIFO_FULL))
    );

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. A queue model of buffered and
//   in-flight fetches predicts every output on each falling edge; directed
//   checks with literal values pin the model at key points.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_hold;
    logic        flush;
    logic        id_stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom_img [256];
    logic [31:0] fc_base = '0;

    // model state, written only by the compare process
    ent_t        mq[$];
    ent_t        delivered[$];
    logic        m_inf = 1'b0;
    ent_t        m_inf_ent;
    logic [31:0] m_pops = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W    (8),
        .NOP_INSTR (NOP),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_valid    (pc_valid),
        .pc_hold     (pc_hold),
        .flush       (flush),
        .id_stall    (id_stall),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_count (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // One clock; the PC steps when its request was accepted.
    task automatic cyc();
        logic acc;
        @(negedge clk);
        acc = pc_valid && !pc_hold && reset;
        @(posedge clk);
        #1;
        if (acc) pc_addr = pc_addr + 32'd1;
    endtask

    // Deliveries since mark must be pcs first_pc.. in order, with ROM words.
    task automatic check_run(input string tag, input int mark, input logic [31:0] first_pc, input int n);
        logic [7:0] idx;
        check({tag, "_count"}, 32'(delivered.size() - mark), 32'(n));
        for (int i = 0; i < n && (mark + i) < delivered.size(); i++) begin
            idx = first_pc[7:0] + 8'(i);
            check({tag, "_pc"}, delivered[mark + i].pc, first_pc + 32'(i));
            check({tag, "_instr"}, delivered[mark + i].instr, rom_img[idx]);
        end
    endtask

    // ---------------------------------------------------------------
    // Model + per-cycle compare
    // ---------------------------------------------------------------
    initial begin : compare_proc
        ent_t        e;
        logic        exp_valid;
        logic        exp_hold;
        logic        acc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mq.delete();
                m_inf     = 1'b0;
                m_pops    = '0;
                exp_valid = 1'b0;
                exp_hold  = 1'b0;
                exp_instr = '0;
                exp_pc    = '0;
            end else begin
                exp_valid = (mq.size() != 0);
                exp_instr = exp_valid ? mq[0].instr : 32'h0;
                exp_pc    = exp_valid ? mq[0].pc    : 32'h0;
                exp_hold  = !flush && ((mq.size() + int'(m_inf)) >= 2);
            end
            check("cyc_instr_valid", 32'(instr_valid), 32'(exp_valid));
            check("cyc_instr", instr, exp_instr);
            check("cyc_instr_pc", instr_pc, exp_pc);
            check("cyc_pc_hold", 32'(pc_hold), 32'(exp_hold));
            check("cyc_fetch_count", fetch_count, m_pops + fc_base);
            if (reset) begin
                acc = pc_valid && !exp_hold;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (exp_valid && !id_stall) begin
                        e = mq.pop_front();
                        delivered.push_back(e);
                        m_pops = m_pops + 32'd1;
                        $display("deliver pc=%08h instr=%08h", e.pc, e.instr);
                    end
                    if (m_inf) mq.push_back(m_inf_ent);
                end
                m_inf = acc;
                if (acc) begin
                    m_inf_ent.pc    = pc_addr;
                    m_inf_ent.instr = (pc_addr[31:8] != 24'd0) ? NOP : rom_img[pc_addr[7:0]];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------
    initial begin : stim_proc
        int mark;
        reset    = 1'b1;
        pc_addr  = '0;
        pc_valid = 1'b0;
        flush    = 1'b0;
        id_stall = 1'b0;
        for (int i = 0; i < 256; i++) rom_img[i] = 32'hA500_0000 | 32'(i);
        rom_img[0] = 32'h11;
        rom_img[1] = 32'h22;
        rom_img[2] = 32'h33;
        rom_img[3] = 32'h44;
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.u_rom.rom_mem[i] = rom_img[i];
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_hold", 32'(pc_hold), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        reset = 1'b1;

        // 1: stream 0..3
        mark     = delivered.size();
        pc_addr  = 32'd0;
        pc_valid = 1'b1;
        cyc();
        cyc();
        check("t1_first_valid", 32'(instr_valid), 32'd1);
        check("t1_first_instr", instr, 32'h11);
        check("t1_first_pc", instr_pc, 32'd0);
        for (int k = 0; k < 40 && pc_addr != 32'd4; k++) cyc();
        check("t1_reach_pc", pc_addr, 32'd4);
        pc_valid = 1'b0;
        repeat (6) cyc();
        check("t1_fetch_count", fetch_count, 32'd4);
        check_run("t1", mark, 32'd0, 4);

        // 2: stall mid-stream, then resume
        mark     = delivered.size();
        pc_valid = 1'b1;
        cyc();
        cyc();
        id_stall = 1'b1;
        repeat (4) cyc();
        check("t2_hold", 32'(pc_hold), 32'd1);
        check("t2_head_pc", instr_pc, 32'd4);
        id_stall = 1'b0;
        for (int k = 0; k < 60 && pc_addr != 32'd12; k++) cyc();
        check("t2_reach_pc", pc_addr, 32'd12);
        pc_valid = 1'b0;
        repeat (6) cyc();
        check("t2_fetch_count", fetch_count, 32'd12);
        check_run("t2", mark, 32'd4, 8);

        // 3: flush while holding pcs 5,6
        mark     = delivered.size();
        pc_addr  = 32'd5;
        pc_valid = 1'b1;
        id_stall = 1'b1;
        repeat (3) cyc();
        check("t3_full_hold", 32'(pc_hold), 32'd1);
        check("t3_full_head", instr_pc, 32'd5);
        flush    = 1'b1;
        pc_addr  = 32'd20;
        id_stall = 1'b0;
        cyc();
        flush    = 1'b0;
        pc_valid = 1'b0;
        check("t3_dropped", 32'(instr_valid), 32'd0);
        cyc();
        check("t3_target_valid", 32'(instr_valid), 32'd1);
        check("t3_target_pc", instr_pc, 32'd20);
        check("t3_target_instr", instr, 32'hA500_0014);
        check("t3_count_kept", fetch_count, 32'd12);
        repeat (4) cyc();
        check_run("t3", mark, 32'd20, 1);
        check("t3_fetch_count", fetch_count, 32'd13);

        // 4: out-of-range address
        pc_addr  = 32'h0000_0100;
        pc_valid = 1'b1;
        cyc();
        pc_valid = 1'b0;
        cyc();
        check("t4_valid", 32'(instr_valid), 32'd1);
        check("t4_nop", instr, NOP);
        check("t4_pc", instr_pc, 32'h0000_0100);
        repeat (3) cyc();
        check("t4_fetch_count", fetch_count, 32'd14);

        // 5: reset mid-operation with a buffered entry and one in flight
        pc_addr  = 32'd8;
        pc_valid = 1'b1;
        id_stall = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("t5_valid", 32'(instr_valid), 32'd0);
        check("t5_instr", instr, 32'd0);
        check("t5_pc", instr_pc, 32'd0);
        check("t5_hold", 32'(pc_hold), 32'd0);
        check("t5_count", fetch_count, 32'd0);
        cyc();
        reset    = 1'b1;
        id_stall = 1'b0;
        pc_addr  = 32'd0;
        pc_valid = 1'b1;
        cyc();
        cyc();
        check("t5_restart_instr", instr, 32'h11);
        check("t5_restart_pc", instr_pc, 32'd0);
        pc_valid = 1'b0;
        repeat (5) cyc();
        check("t5_fetch_count", fetch_count, 32'd2);

        // 6: fetch_count wrap
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        fc_base = 32'hFFFF_FFFF - m_pops;
        check("t6_preload", fetch_count, 32'hFFFF_FFFF);
        pc_addr  = 32'd3;
        pc_valid = 1'b1;
        cyc();
        pc_valid = 1'b0;
        repeat (4) cyc();
        check("t6_wrap", fetch_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_instr_fetch_unit
